// File: rtl/cwe1234_pkg.sv
// Shared encodings for the lockable-register initiator.
// Latency: n/a (types only).
// Backpressure: n/a.
package cwe1234_pkg;

  // Host request opcodes, matching the Req_op encoding.
  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_LOCK       = 2'b01,
    OP_DBG_UNLOCK = 2'b10,
    OP_DBG_RELOCK = 2'b11
  } op_t;

  // Response status codes, matching the Rsp_status encoding.
  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_DENIED  = 2'b01,
    ST_LOCKOUT = 2'b10
  } status_t;

  // Request sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/cwe1234_lockout_timer.sv
// Counts consecutive wrong debug keys and runs the lockout countdown.
// Latency: strobes take effect on the next edge; locked_out is registered state.
// Backpressure: none; caller must not raise fail_stb while locked_out.
module cwe1234_lockout_timer #(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic fail_stb,
  input  logic ok_stb,
  output logic locked_out
);

  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = $clog2(LOCKOUT_CYCLES + 1);

  logic [FCW-1:0] fail_cnt_q;
  logic [TW-1:0]  timer_q;

  // Fail counter and countdown; a fail that reaches the limit arms the timer
  // and restarts the count, a successful key restarts the count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fail_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      if (timer_q != '0) begin
        timer_q <= timer_q - TW'(1);
      end
      if (ok_stb) begin
        fail_cnt_q <= '0;
      end else if (fail_stb) begin
        if (fail_cnt_q == FCW'(MAX_FAILS - 1)) begin
          fail_cnt_q <= '0;
          timer_q    <= TW'(LOCKOUT_CYCLES);
        end else begin
          fail_cnt_q <= fail_cnt_q + FCW'(1);
        end
      end
    end
  end

  // Registered (pre-decrement) value decides, so a count of 1 still locks out.
  assign locked_out = (timer_q != '0);

endmodule

// File: rtl/cwe1234_lock_initiator.sv
// Sequences write/Lock/debug-unlock controls of a lockable config register.
// Latency: accept at N, write/Lock pulse in N+1, Rsp_valid in N+2, ready at N+3.
// Backpressure: Req_ready only in IDLE; responses are never backpressured.
module cwe1234_lock_initiator
  import cwe1234_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter logic [DATA_W-1:0] DBG_KEY        = 16'hA5C3,
  parameter int                MAX_FAILS      = 3,
  parameter int                LOCKOUT_CYCLES = 1024
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [1:0]        Req_op,
  input  logic [DATA_W-1:0] Req_data,
  output logic              Rsp_valid,
  output logic [1:0]        Rsp_status,
  output logic [DATA_W-1:0] Data_in,
  output logic              write,
  output logic              Lock,
  output logic              debug_unlocked,
  output logic              lock_status
);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] din_q, din_d;
  status_t           status_q, status_d;
  logic              lock_q, lock_d;
  logic              dbg_q, dbg_d;
  logic              wr_pulse, lk_pulse;
  logic              fail_stb, ok_stb, locked_out;

  cwe1234_lockout_timer #(
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .fail_stb   (fail_stb),
    .ok_stb     (ok_stb),
    .locked_out (locked_out)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Capture the request into holding registers on the accept edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q   <= OP_WRITE;
      data_q <= '0;
    end else if (Req_valid && (state_q == S_IDLE)) begin
      op_q   <= op_t'(Req_op);
      data_q <= Req_data;
    end
  end

  // Next state, ISSUE-cycle decisions and strobes.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    lock_d   = lock_q;
    dbg_d    = dbg_q;
    din_d    = din_q;
    wr_pulse = 1'b0;
    lk_pulse = 1'b0;
    fail_stb = 1'b0;
    ok_stb   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_RESP;
        case (op_q)
          OP_WRITE: begin
            if (!lock_q || dbg_q) begin
              wr_pulse = 1'b1;
              din_d    = data_q;
              status_d = ST_OK;
            end else begin
              status_d = ST_DENIED;
            end
          end
          OP_LOCK: begin
            lk_pulse = 1'b1;
            lock_d   = 1'b1;
            status_d = ST_OK;
          end
          OP_DBG_UNLOCK: begin
            if (locked_out) begin
              status_d = ST_LOCKOUT;
            end else if (data_q == DBG_KEY) begin
              dbg_d    = 1'b1;
              ok_stb   = 1'b1;
              status_d = ST_OK;
            end else begin
              fail_stb = 1'b1;
              status_d = ST_DENIED;
            end
          end
          default: begin
            dbg_d    = 1'b0;
            status_d = ST_OK;
          end
        endcase
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status, sticky lock, debug override and held register data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      status_q <= ST_OK;
      lock_q   <= 1'b0;
      dbg_q    <= 1'b0;
      din_q    <= '0;
    end else begin
      status_q <= status_d;
      lock_q   <= lock_d;
      dbg_q    <= dbg_d;
      din_q    <= din_d;
    end
  end

  // Data_in shows new data during the ISSUE write pulse and holds it after.
  assign Data_in        = din_d;
  assign write          = wr_pulse;
  assign Lock           = lk_pulse;
  assign Req_ready      = (state_q == S_IDLE);
  assign Rsp_valid      = (state_q == S_RESP);
  assign Rsp_status     = status_q;
  assign lock_status    = lock_q;
  assign debug_unlocked = dbg_q;

endmodule

// File: tb/tb_cwe1234_lock_initiator.sv
// Directed bench for the lockable-register initiator.
// Latency: checks pulses at N+1 and response at N+2 after each accept.
// Backpressure: host waits for Req_ready before presenting each request.
module tb_cwe1234_lock_initiator;

  logic        Clk;
  logic        Rst_n;
  logic        Req_valid;
  logic        Req_ready;
  logic [1:0]  Req_op;
  logic [15:0] Req_data;
  logic        Rsp_valid;
  logic [1:0]  Rsp_status;
  logic [15:0] Data_in;
  logic        write;
  logic        Lock;
  logic        debug_unlocked;
  logic        lock_status;

  int n_checks;
  int n_fails;

  localparam logic [1:0] OP_WR = 2'b00, OP_LK = 2'b01, OP_UN = 2'b10, OP_RL = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_DN = 2'b01, ST_LO = 2'b10;
  localparam logic [15:0] KEY = 16'hA5C3;

  cwe1234_lock_initiator dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .Req_valid      (Req_valid),
    .Req_ready      (Req_ready),
    .Req_op         (Req_op),
    .Req_data       (Req_data),
    .Rsp_valid      (Rsp_valid),
    .Rsp_status     (Rsp_status),
    .Data_in        (Data_in),
    .write          (write),
    .Lock           (Lock),
    .debug_unlocked (debug_unlocked),
    .lock_status    (lock_status)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full request: present at a negedge, check ISSUE and RESP cycles.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [15:0] dat,
                        input logic exp_wr, input logic exp_lk,
                        input logic [1:0] exp_st, input logic [15:0] exp_din);
    @(negedge Clk);
    check({tag, ".ready"}, 32'(Req_ready), 32'd1);
    Req_valid = 1'b1;
    Req_op    = op;
    Req_data  = dat;
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    Req_data  = 16'h0;
    @(negedge Clk);
    check({tag, ".issue_write"}, 32'(write), 32'(exp_wr));
    check({tag, ".issue_lock"}, 32'(Lock), 32'(exp_lk));
    check({tag, ".issue_din"}, 32'(Data_in), 32'(exp_din));
    check({tag, ".issue_rspv"}, 32'(Rsp_valid), 32'd0);
    check({tag, ".issue_ready"}, 32'(Req_ready), 32'd0);
    @(negedge Clk);
    check({tag, ".resp_rspv"}, 32'(Rsp_valid), 32'd1);
    check({tag, ".resp_status"}, 32'(Rsp_status), 32'(exp_st));
    check({tag, ".resp_write"}, 32'(write), 32'd0);
    check({tag, ".resp_lock"}, 32'(Lock), 32'd0);
    check({tag, ".resp_din"}, 32'(Data_in), 32'(exp_din));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    Rst_n     = 1'b0;
    Req_valid = 1'b0;
    Req_op    = 2'b00;
    Req_data  = 16'h0;
    repeat (2) @(negedge Clk);
    check("rst.ready", 32'(Req_ready), 32'd1);
    check("rst.rspv", 32'(Rsp_valid), 32'd0);
    check("rst.status", 32'(Rsp_status), 32'd0);
    check("rst.din", 32'(Data_in), 32'd0);
    check("rst.write", 32'(write), 32'd0);
    check("rst.lock", 32'(Lock), 32'd0);
    check("rst.dbg", 32'(debug_unlocked), 32'd0);
    check("rst.lock_status", 32'(lock_status), 32'd0);
    Rst_n = 1'b1;

    // Basic write, then lock, then a denied write.
    do_req("wr1234", OP_WR, 16'h1234, 1'b1, 1'b0, ST_OK, 16'h1234);
    check("wr1234.lock_status", 32'(lock_status), 32'd0);
    do_req("lock", OP_LK, 16'h0, 1'b0, 1'b1, ST_OK, 16'h1234);
    check("lock.lock_status", 32'(lock_status), 32'd1);
    do_req("lock_again", OP_LK, 16'h0, 1'b0, 1'b1, ST_OK, 16'h1234);
    check("lock_again.lock_status", 32'(lock_status), 32'd1);
    do_req("wrBEEF", OP_WR, 16'hBEEF, 1'b0, 1'b0, ST_DN, 16'h1234);

    // Debug override allows writes while locked; relock denies again.
    do_req("unlock", OP_UN, KEY, 1'b0, 1'b0, ST_OK, 16'h1234);
    check("unlock.dbg", 32'(debug_unlocked), 32'd1);
    do_req("wr5555", OP_WR, 16'h5555, 1'b1, 1'b0, ST_OK, 16'h5555);
    do_req("relock", OP_RL, 16'h0, 1'b0, 1'b0, ST_OK, 16'h5555);
    check("relock.dbg", 32'(debug_unlocked), 32'd0);
    do_req("wr1111", OP_WR, 16'h1111, 1'b0, 1'b0, ST_DN, 16'h5555);

    // Three wrong keys arm a 1024-cycle lockout.
    do_req("bad1", OP_UN, 16'h0000, 1'b0, 1'b0, ST_DN, 16'h5555);
    do_req("bad2", OP_UN, 16'h0000, 1'b0, 1'b0, ST_DN, 16'h5555);
    do_req("bad3", OP_UN, 16'h0000, 1'b0, 1'b0, ST_DN, 16'h5555);
    repeat (10) @(negedge Clk);
    do_req("lockout_key", OP_UN, KEY, 1'b0, 1'b0, ST_LO, 16'h5555);
    check("lockout_key.dbg", 32'(debug_unlocked), 32'd0);
    do_req("relock_lo", OP_RL, 16'h0, 1'b0, 1'b0, ST_OK, 16'h5555);
    // Timer reads exactly 1 during the next ISSUE: still locked out.
    repeat (1005) @(negedge Clk);
    do_req("lockout_last", OP_UN, KEY, 1'b0, 1'b0, ST_LO, 16'h5555);
    check("lockout_last.dbg", 32'(debug_unlocked), 32'd0);
    do_req("after_lockout", OP_UN, KEY, 1'b0, 1'b0, ST_OK, 16'h5555);
    check("after_lockout.dbg", 32'(debug_unlocked), 32'd1);

    // Success clears the fail count, so 2 + 1 wrong keys do not lock out.
    do_req("f1", OP_UN, 16'h1357, 1'b0, 1'b0, ST_DN, 16'h5555);
    do_req("f2", OP_UN, 16'h2468, 1'b0, 1'b0, ST_DN, 16'h5555);
    do_req("fok", OP_UN, KEY, 1'b0, 1'b0, ST_OK, 16'h5555);
    do_req("f3", OP_UN, 16'hFFFF, 1'b0, 1'b0, ST_DN, 16'h5555);
    do_req("fok2", OP_UN, KEY, 1'b0, 1'b0, ST_OK, 16'h5555);
    do_req("wr7777", OP_WR, 16'h7777, 1'b1, 1'b0, ST_OK, 16'h7777);

    // Reset during ISSUE of a LOCK drops the pulse, response and lock state.
    @(negedge Clk);
    Req_valid = 1'b1;
    Req_op    = OP_LK;
    Req_data  = 16'h0;
    @(posedge Clk);
    #1;
    Req_valid = 1'b0;
    check("mid.lock_before", 32'(Lock), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid.lock_dropped", 32'(Lock), 32'd0);
    @(negedge Clk);
    check("mid.rspv", 32'(Rsp_valid), 32'd0);
    check("mid.lock_status", 32'(lock_status), 32'd0);
    check("mid.ready", 32'(Req_ready), 32'd1);
    check("mid.din", 32'(Data_in), 32'd0);
    check("mid.dbg", 32'(debug_unlocked), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("mid.rspv_after", 32'(Rsp_valid), 32'd0);
    do_req("wrCAFE", OP_WR, 16'hCAFE, 1'b1, 1'b0, ST_OK, 16'hCAFE);
    check("wrCAFE.lock_status", 32'(lock_status), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
